ysyx_25040111_lsu_axi: RTL and testbench
========================================

Name: ysyx_25040111_lsu_axi

Overview:
Parametrised load/store unit. It is the next generation of the single-beat LSU and masters one AXI4 port for both reads and writes.
- Latches each request, so upstream may change its inputs after acceptance.
- Supports 32- or 64-bit data paths and INCR read bursts up to MAX_LEN beats.
- Detects misaligned and illegal requests and reports AXI error responses.
- Sits between the EXU/ICache refill logic and the SoC crossbar (io_master_*).

Parameters:
DATA_W, 32, AXI data width; legal values are 32 or 64. OFS_W = log2(DATA_W/8).
ADDR_W, 32, address width.
MAX_LEN, 8, maximum read burst length in beats (power of two, at most 256).
AXI_ID, 0, constant value driven on awid and arid.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request strobe.
req_ready  out  1  high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_size  in  3  log2 of bytes per beat.
req_sign  in  1  sign-extend load data.
req_len  in  8  number of beats minus 1 (loads only).
req_wdata  in  DATA_W  store data, LSB-aligned.
rsp_valid  out  1  one-cycle pulse per beat or per store completion; there is no backpressure.
rsp_data  out  DATA_W  extracted and extended load data; 0 for stores.
rsp_last  out  1  final response of the request.
rsp_err  out  2  00 ok, 01 misaligned/illegal, 10 bus error, 11 rlast mismatch.
io_master_aw*  out/in  -  awvalid, awaddr[ADDR_W], awid[4], awlen[8], awsize[3], awburst[2] out; awready in.
io_master_w*  out/in  -  wvalid, wdata[DATA_W], wstrb[DATA_W/8], wlast out; wready in.
io_master_b*  out/in  -  bready out; bvalid, bresp[2], bid[4] in.
io_master_ar*  out/in  -  arvalid, araddr, arid, arlen, arsize, arburst out; arready in.
io_master_r*  out/in  -  rready out; rvalid, rdata[DATA_W], rresp[2], rlast, rid[4] in.

Behaviour:
- Reset (async): state IDLE; all *valid outputs, rsp_* outputs and the beat counter are 0. Reset asserted mid-transaction abandons the transaction; the slave is reset by the same signal.
- FSM states: IDLE, CHK, AR, R, AWW, B, FLT.
- IDLE: req_ready = 1. On handshake, latch all req_* fields and go to CHK.
- CHK (one cycle): the request is illegal if any of the following holds:
  - addr[size-1:0] != 0;
  - size > OFS_W;
  - req_len != 0 and (size != OFS_W or we);
  - req_len >= MAX_LEN.
  Illegal requests go to FLT. Legal loads go to AR; legal stores go to AWW.
- FLT: drive rsp_valid = 1, rsp_last = 1, rsp_err = 01, rsp_data = 0; go to IDLE. No AXI traffic is issued.
- AR: arvalid held high until arready.
  - araddr = latched addr; arlen = len; arsize = size; arburst = 01 (INCR); arid = AXI_ID.
  - On handshake go to R.
- R: rready = 1. Each rvalid beat produces a registered response one cycle later.
  - rsp_data: rdata shifted right by addr[OFS_W-1:0]*8 (first beat only; burst beats are full width). It is then truncated to 8·2^size bits and sign-extended when req_sign is set, else zero-extended.
  - rsp_err = 10 if rresp != 00. rsp_err = 11 if rlast differs from (count == len); error precedence is 11 > 10.
  - Beat count == len: rsp_last = 1, go to IDLE. Termination follows the counter, not rlast.
- AWW: awvalid and wvalid rise together on entry and each drops independently on its own handshake.
  - wdata = req_wdata << (addr[OFS_W-1:0]*8).
  - wstrb = ((1 << 2^size) - 1) << addr[OFS_W-1:0].
  - awlen = 0; wlast = 1.
  - Go to B once both handshakes are complete. AW and W handshaking in the same cycle is legal.
- B: bready = 1. On bvalid, one cycle later drive rsp_valid = 1, rsp_last = 1, rsp_err = (bresp != 00) ? 10 : 00; go to IDLE.
- A response pulse and a new request acceptance may occur in the same cycle, because the FSM is in IDLE while rsp_valid is high.
- bid and rid are ignored because there is a single outstanding transaction.

Decomposition:
- Shared package/header ysyx_25040111_inc.vh holds:
  - FSM state encodings;
  - RSP_OK / RSP_MISAL / RSP_BUSERR / RSP_LASTERR;
  - AXI_BURST_INCR and AXI_RESP_OKAY constants.
- One sub-module, ysyx_25040111_lsu_lane: combinational byte-lane steering. It handles the store shift, wstrb generation, and load extraction/extension. It is parametrised by DATA_W and shared with future DMA logic.

Test Plan:
- DATA_W=32 load, addr 0x8000_0003, size 0, sign=1, rdata 0x80xx_xxxx -> rsp_data 0xFFFF_FF80, err 00, last 1.
- Store, addr 0x8000_0002, size 1, wdata 0x1234; awready delayed 3 cycles after wready -> wdata 0x1234_0000, wstrb 1100, single rsp after B.
- Load, addr 0x8000_0002, size 2 -> FLT: rsp_err 01 two cycles after accept; arvalid never rises.
- Burst load, len 3, size 2, arready stalled 2 cycles, rvalid gaps -> arlen 3, four rsp pulses, rsp_last only on the 4th.
- Burst with rlast on beat 2 of 4 -> beat 2 reports err 11; transfer still ends after beat 4.
- Store with bresp 10, then reset asserted during a following AR -> err 10 reported; arvalid and rsp_valid drop immediately on reset.

Source files
------------

// File: rtl/ysyx_25040111_lsu_axi_pkg.sv
// ysyx_25040111_lsu_axi_pkg: shared FSM encodings, response codes and AXI constants for the LSU
package ysyx_25040111_lsu_axi_pkg;

  typedef logic [2:0] lsu_state_t;
  typedef logic [1:0] rsp_err_t;

  localparam lsu_state_t S_IDLE = 3'd0;
  localparam lsu_state_t S_CHK  = 3'd1;
  localparam lsu_state_t S_AR   = 3'd2;
  localparam lsu_state_t S_R    = 3'd3;
  localparam lsu_state_t S_AWW  = 3'd4;
  localparam lsu_state_t S_B    = 3'd5;
  localparam lsu_state_t S_FLT  = 3'd6;

  localparam rsp_err_t RSP_OK      = 2'b00;
  localparam rsp_err_t RSP_MISAL   = 2'b01;
  localparam rsp_err_t RSP_BUSERR  = 2'b10;
  localparam rsp_err_t RSP_LASTERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ysyx_25040111_lsu_axi_lane.sv
// ysyx_25040111_lsu_lane: combinational byte-lane steering for store alignment and load extraction
module ysyx_25040111_lsu_lane #(
  parameter int DATA_W = 32,
  localparam int OFS_W = $clog2(DATA_W / 8),
  localparam int SW = DATA_W / 8
) (
  input  logic [OFS_W-1:0]  ofs,
  input  logic [2:0]        size,
  input  logic              sign,
  input  logic              first,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] st_wdata,
  output logic [SW-1:0]     st_strb,
  output logic [DATA_W-1:0] ld_data
);

  logic [2:0]        sz;
  logic [DATA_W-1:0] sh;
  logic              msb;

  // Oversized requests never reach the bus, so clamping keeps every index in range
  always_comb begin
    sz = (size > 3'(OFS_W)) ? 3'(OFS_W) : size;
    st_wdata = st_data << {ofs, 3'b000};
    st_strb = SW'((32'd1 << (32'd1 << sz)) - 32'd1) << ofs;
    sh = first ? ld_raw >> {ofs, 3'b000} : ld_raw;
    msb = (sz == 3'd0) ? sh[7] : (sz == 3'd1) ? sh[15] : (sz == 3'd2) ? sh[31] : sh[DATA_W-1];
    ld_data = '0;
    for (int i = 0; i < DATA_W; i++)
      ld_data[i] = (i < (8 << sz)) ? sh[i] : (sign & msb);
  end

endmodule

// File: rtl/ysyx_25040111_lsu_axi.sv
// ysyx_25040111_lsu_axi: load/store unit mastering one AXI4 port with read bursts and error reporting
module ysyx_25040111_lsu_axi
  import ysyx_25040111_lsu_axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MAX_LEN = 8,
  parameter int AXI_ID = 0,
  localparam int OFS_W = $clog2(DATA_W / 8),
  localparam int SW = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic              req_sign,
  input  logic [7:0]        req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [1:0]        rsp_err,
  output logic              io_master_awvalid,
  input  logic              io_master_awready,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic [3:0]        io_master_awid,
  output logic [7:0]        io_master_awlen,
  output logic [2:0]        io_master_awsize,
  output logic [1:0]        io_master_awburst,
  output logic              io_master_wvalid,
  input  logic              io_master_wready,
  output logic [DATA_W-1:0] io_master_wdata,
  output logic [SW-1:0]     io_master_wstrb,
  output logic              io_master_wlast,
  output logic              io_master_bready,
  input  logic              io_master_bvalid,
  input  logic [1:0]        io_master_bresp,
  input  logic [3:0]        io_master_bid,
  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [3:0]        io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  output logic              io_master_rready,
  input  logic              io_master_rvalid,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rlast,
  input  logic [3:0]        io_master_rid
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [7:0]        len_q, len_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q, w_pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_last_q, rsp_last_d;
  rsp_err_t          rsp_err_q, rsp_err_d;
  logic [7:0]        amask;
  logic              illegal;
  logic              beat_last;
  logic [DATA_W-1:0] lane_wdata;
  logic [SW-1:0]     lane_strb;
  logic [DATA_W-1:0] lane_ldata;
  logic              unused_ids;

  ysyx_25040111_lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .ofs      (addr_q[OFS_W-1:0]),
    .size     (size_q),
    .sign     (sign_q),
    .first    (cnt_q == 8'd0),
    .st_data  (wdata_q),
    .ld_raw   (io_master_rdata),
    .st_wdata (lane_wdata),
    .st_strb  (lane_strb),
    .ld_data  (lane_ldata)
  );

  assign unused_ids = ^{io_master_bid, io_master_rid};

  // Legality of the latched request: alignment, size vs bus width, burst shape and length
  always_comb begin
    amask = 8'((9'd1 << size_q) - 9'd1);
    beat_last = cnt_q == len_q;
    illegal = (|(addr_q[7:0] & amask)) || (size_q > 3'(OFS_W)) ||
              ((len_q != 8'd0) && ((size_q != 3'(OFS_W)) || we_q)) ||
              ({24'd0, len_q} >= 32'(MAX_LEN));
  end

  // Request sequencing and registered response generation
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    we_d = we_q;
    size_d = size_q;
    sign_d = sign_q;
    len_d = len_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    aw_pend_d = aw_pend_q;
    w_pend_d = w_pend_q;
    rsp_valid_d = 1'b0;
    rsp_data_d = '0;
    rsp_last_d = 1'b0;
    rsp_err_d = RSP_OK;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d = req_addr;
        we_d = req_we;
        size_d = req_size;
        sign_d = req_sign;
        len_d = req_len;
        wdata_d = req_wdata;
        state_d = S_CHK;
      end
      S_CHK: begin
        cnt_d = 8'd0;
        aw_pend_d = !illegal && we_q;
        w_pend_d = !illegal && we_q;
        state_d = illegal ? S_FLT : we_q ? S_AWW : S_AR;
      end
      S_FLT: begin
        rsp_valid_d = 1'b1;
        rsp_last_d = 1'b1;
        rsp_err_d = RSP_MISAL;
        state_d = S_IDLE;
      end
      S_AR: state_d = io_master_arready ? S_R : S_AR;
      S_R: if (io_master_rvalid) begin
        rsp_valid_d = 1'b1;
        rsp_data_d = lane_ldata;
        rsp_last_d = beat_last;
        rsp_err_d = (io_master_rlast != beat_last) ? RSP_LASTERR :
                    (io_master_rresp != AXI_RESP_OKAY) ? RSP_BUSERR : RSP_OK;
        cnt_d = beat_last ? 8'd0 : cnt_q + 8'd1;
        state_d = beat_last ? S_IDLE : S_R;
      end
      S_AWW: begin
        aw_pend_d = aw_pend_q && !io_master_awready;
        w_pend_d = w_pend_q && !io_master_wready;
        state_d = (aw_pend_d || w_pend_d) ? S_AWW : S_B;
      end
      S_B: if (io_master_bvalid) begin
        rsp_valid_d = 1'b1;
        rsp_last_d = 1'b1;
        rsp_err_d = (io_master_bresp != AXI_RESP_OKAY) ? RSP_BUSERR : RSP_OK;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched request; reset abandons any transaction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      size_q <= '0;
      sign_q <= 1'b0;
      len_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q <= RSP_OK;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      size_q <= size_d;
      sign_q <= sign_d;
      len_q <= len_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q <= w_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready = state_q == S_IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_last = rsp_last_q;
  assign rsp_err = rsp_err_q;

  assign io_master_awvalid = (state_q == S_AWW) && aw_pend_q;
  assign io_master_awaddr = addr_q;
  assign io_master_awid = 4'(AXI_ID);
  assign io_master_awlen = 8'd0;
  assign io_master_awsize = size_q;
  assign io_master_awburst = AXI_BURST_INCR;
  assign io_master_wvalid = (state_q == S_AWW) && w_pend_q;
  assign io_master_wdata = lane_wdata;
  assign io_master_wstrb = lane_strb;
  assign io_master_wlast = 1'b1;
  assign io_master_bready = state_q == S_B;

  assign io_master_arvalid = state_q == S_AR;
  assign io_master_araddr = addr_q;
  assign io_master_arid = 4'(AXI_ID);
  assign io_master_arlen = len_q;
  assign io_master_arsize = size_q;
  assign io_master_arburst = AXI_BURST_INCR;
  assign io_master_rready = state_q == S_R;

endmodule

// File: tb/tb_ysyx_25040111_lsu_axi.sv
// tb_ysyx_25040111_lsu_axi: directed bench with a response-queue model for the AXI LSU
module tb_ysyx_25040111_lsu_axi;

  typedef logic [31:0] w8_t [8];
  typedef logic        b8_t [8];
  typedef logic [1:0]  r8_t [8];
  typedef int          i8_t [8];
  typedef struct {logic [31:0] d; logic last; logic [1:0] err;} rsp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 0, req_we = 0, req_sign = 0;
  logic        req_ready;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0]  req_size = 0;
  logic [7:0]  req_len = 0;
  logic        rsp_valid, rsp_last;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        awvalid, awready = 0, wvalid, wready = 0, wlast, bready, bvalid = 0;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  awid, arid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp = 0, rresp = 0;
  logic        arvalid, arready = 0, rready, rvalid = 0, rlast = 0;
  logic [31:0] rdata = 0;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ysyx_25040111_lsu_axi dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_sign(req_sign), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
    .io_master_bid(4'd0),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rdata(rdata),
    .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(4'd0)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Load result: pick the addressed bytes, then sign/zero extend to 32 bits
  function automatic logic [31:0] m_load(input logic [31:0] a, input int sz, input bit sgn,
                                          input logic [31:0] rd, input bit first);
    logic [63:0] v;
    int nb, ofs;
    nb = 1 << sz;
    ofs = first ? int'(a % 4) : 0;
    v = 0;
    for (int b = 0; b < nb; b++) v = v | (64'((rd >> (8 * (ofs + b))) & 32'hFF) << (8 * b));
    if (sgn && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] a, input logic [31:0] d);
    return d << (8 * (a % 4));
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] a, input int sz);
    logic [7:0] m;
    m = 8'((1 << (1 << sz)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic bit m_legal(input logic [31:0] a, input int sz, input bit we, input int len);
    return (a % (1 << sz) == 0) && (sz <= 2) && !(len != 0 && (sz != 2 || we)) && (len < 8);
  endfunction

  function automatic logic [1:0] m_rerr(input bit rl, input logic [1:0] rr, input bit is_last);
    return (rl != is_last) ? 2'b11 : (rr != 2'b00) ? 2'b10 : 2'b00;
  endfunction

  task automatic push(input logic [31:0] d, input logic last, input logic [1:0] err);
    rsp_t e;
    e.d = d; e.last = last; e.err = err;
    exp_q.push_back(e);
  endtask

  // Every response pulse must match the next queued expectation
  always @(negedge clock) begin : cmp_p
    rsp_t e;
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_last", rsp_last, e.last);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_req(input bit we, input logic [31:0] a, input int sz, input bit sgn,
                        input int len, input logic [31:0] wd);
    req_valid = 1; req_we = we; req_addr = a; req_size = 3'(sz);
    req_sign = sgn; req_len = 8'(len); req_wdata = wd;
    chk("req_ready", req_ready, 1);
    step();
    req_valid = 0; req_we = ~we; req_addr = $urandom; req_size = 3'($urandom);
    req_sign = ~sgn; req_len = 8'($urandom); req_wdata = $urandom;
  endtask

  task automatic run_load(input logic [31:0] a, input int sz, input bit sgn, input int len,
                          input int stall, input w8_t rd, input b8_t rl, input r8_t rr, input i8_t gp);
    int w;
    do_req(0, a, sz, sgn, len, 32'h0);
    w = 0;
    while (!arvalid && w < 20) begin step(); w++; end
    chk("arvalid_rise", arvalid, 1);
    chk("awvalid_on_load", awvalid, 0);
    repeat (stall) begin step(); chk("arvalid_hold", arvalid, 1); end
    chk("araddr", araddr, a);
    chk("arlen", arlen, 8'(len));
    chk("arsize", arsize, 3'(sz));
    chk("arburst", arburst, 2'b01);
    chk("arid", arid, 4'd0);
    arready = 1; step(); arready = 0;
    chk("arvalid_drop", arvalid, 0);
    for (int i = 0; i <= len; i++) begin
      repeat (gp[i]) step();
      chk("rready", rready, 1);
      rvalid = 1; rdata = rd[i]; rlast = rl[i]; rresp = rr[i];
      push(m_load(a, sz, sgn, rd[i], i == 0), i == len, m_rerr(rl[i], rr[i], i == len));
      step();
      rvalid = 0; rlast = 0; rresp = 0;
    end
    chk("rready_done", rready, 0);
  endtask

  task automatic run_store(input logic [31:0] a, input int sz, input logic [31:0] wd,
                           input int w_dly, input int aw_dly, input int b_dly, input logic [1:0] br);
    int w;
    bit aw_p, w_p, aw_hs, w_hs;
    do_req(1, a, sz, 0, 0, wd);
    w = 0;
    while (!awvalid && !wvalid && w < 20) begin step(); w++; end
    chk("aw_w_together", {awvalid, wvalid}, 2'b11);
    aw_p = 1; w_p = 1;
    for (int c = 0; (aw_p || w_p) && c < 30; c++) begin
      chk("awvalid_state", awvalid, aw_p);
      chk("wvalid_state", wvalid, w_p);
      aw_hs = aw_p && c >= aw_dly;
      w_hs = w_p && c >= w_dly;
      awready = aw_hs; wready = w_hs;
      if (aw_hs) begin
        chk("awaddr", awaddr, a);
        chk("awlen", awlen, 8'd0);
        chk("awsize", awsize, 3'(sz));
        chk("awburst", awburst, 2'b01);
      end
      if (w_hs) begin
        chk("wdata", wdata, m_wdata(a, wd));
        chk("wstrb", wstrb, m_strb(a, sz));
        chk("wlast", wlast, 1);
      end
      step();
      awready = 0; wready = 0;
      if (aw_hs) aw_p = 0;
      if (w_hs) w_p = 0;
    end
    chk("aw_w_done", {aw_p, w_p}, 2'b00);
    chk("arvalid_on_store", arvalid, 0);
    repeat (b_dly) begin chk("bready_wait", bready, 1); step(); end
    chk("bready", bready, 1);
    bvalid = 1; bresp = br;
    push(32'h0, 1, (br != 2'b00) ? 2'b10 : 2'b00);
    step();
    bvalid = 0; bresp = 0;
  endtask

  task automatic run_illegal(input bit we, input logic [31:0] a, input int sz, input int len);
    chk("pin_illegal", m_legal(a, sz, we, len), 0);
    do_req(we, a, sz, 0, len, 32'hDEADBEEF);
    chk("flt_quiet_chk", {arvalid, awvalid, wvalid, rsp_valid}, 4'b0000);
    push(32'h0, 1, 2'b01);
    step();
    chk("flt_quiet_flt", {arvalid, awvalid, wvalid, rsp_valid}, 4'b0000);
    step();
    chk("flt_rsp_valid", rsp_valid, 1);
    chk("flt_no_axi", {arvalid, awvalid, wvalid}, 3'b000);
    step();
    chk("flt_pulse_end", {arvalid, awvalid, rsp_valid}, 3'b000);
  endtask

  initial begin
    int w;
    repeat (3) step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {arvalid, awvalid, wvalid, rsp_valid, bready, rready}, 6'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_last_err", {rsp_last, rsp_err}, 3'b000);
    reset = 0;
    step();

    chk("pin_load_byte", m_load(32'h80000003, 0, 1, 32'h80123456, 1), 32'hFFFFFF80);
    chk("pin_load_half", m_load(32'h80000002, 1, 1, 32'hBEEF1234, 1), 32'hFFFFBEEF);
    chk("pin_wdata", m_wdata(32'h80000002, 32'h1234), 32'h12340000);
    chk("pin_wstrb", m_strb(32'h80000002, 1), 4'b1100);
    chk("pin_wstrb_byte", m_strb(32'h80000001, 0), 4'b0010);

    run_load(32'h80000003, 0, 1, 0, 0, '{32'h80123456, 0, 0, 0, 0, 0, 0, 0},
             '{1, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    run_store(32'h80000002, 1, 32'h00001234, 0, 3, 1, 2'b00);
    run_illegal(0, 32'h80000002, 2, 0);
    run_illegal(0, 32'h80000001, 1, 0);
    run_illegal(0, 32'h80000000, 3, 0);
    run_illegal(0, 32'h80000000, 1, 1);
    run_illegal(1, 32'h80000000, 2, 1);
    run_illegal(0, 32'h80000000, 2, 8);
    run_load(32'h80000010, 2, 0, 3, 2, '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 0, 0},
             '{0, 0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 2, 1, 0, 0, 0, 0});
    run_load(32'h80000020, 2, 0, 3, 0, '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 0, 0, 0, 0},
             '{0, 1, 0, 1, 0, 0, 0, 0}, '{0, 2, 2, 0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 0, 0, 0});
    run_load(32'h80000002, 1, 0, 0, 1, '{32'hBEEF1234, 0, 0, 0, 0, 0, 0, 0},
             '{1, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    run_load(32'h80000002, 1, 1, 0, 0, '{32'hBEEF1234, 0, 0, 0, 0, 0, 0, 0},
             '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    run_load(32'h80000040, 2, 1, 7, 0, '{32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06, 32'h07, 32'h87654321},
             '{0, 0, 0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    run_store(32'h80000001, 0, 32'h000000A5, 0, 0, 0, 2'b00);
    run_store(32'h80000004, 2, 32'hCAFEF00D, 2, 0, 0, 2'b00);
    run_store(32'h80000008, 2, 32'h5A5A5A5A, 1, 1, 2, 2'b10);

    do_req(0, 32'h80000020, 2, 0, 0, 32'h0);
    w = 0;
    while (!arvalid && w < 20) begin step(); w++; end
    chk("rst_ar_rise", arvalid, 1);
    #2 reset = 1;
    #1;
    chk("rst_ar_drop", arvalid, 0);
    chk("rst_rsp_drop", rsp_valid, 0);
    chk("rst_idle", req_ready, 1);
    step(); step();
    reset = 0;
    step();
    run_load(32'h80000008, 2, 0, 0, 0, '{32'h13572468, 0, 0, 0, 0, 0, 0, 0},
             '{1, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    step(); step();
    chk("rsp_missing", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
